// File: rtl/rs_pkg.sv
// Shared GF(2^8) definitions for the Reed-Solomon error-magnitude stage:
// field constants, codeword tracking states and combinational field arithmetic.
package rs_pkg;

    localparam int SYM_W = 8;

    // Low byte of x^8+x^7+x^2+x+1; bit 8 is implied by the shift-out.
    localparam logic [SYM_W-1:0] GF_POLY = 8'h87;

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } cw_state_t;

    // Shift-and-add multiply with modular reduction on every shift.
    function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                                input logic [SYM_W-1:0] b);
        logic [SYM_W-1:0] acc;
        logic [SYM_W-1:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < SYM_W; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = sh[SYM_W-1] ? ((sh << 1) ^ GF_POLY) : (sh << 1);
        end
        return acc;
    endfunction

    // a^254 == a^-1 for non-zero a; 254 = 2+4+...+128, so accumulate the squares.
    // Zero maps to zero, which makes the magnitude vanish for a degenerate root.
    function automatic logic [SYM_W-1:0] gf_inv(input logic [SYM_W-1:0] a);
        logic [SYM_W-1:0] sq;
        logic [SYM_W-1:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 0; i < SYM_W - 1; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

endpackage

// File: rtl/rs_decode_mag_inv.sv
// Constant 256-entry GF(2^8) inverse table; contents are folded at elaboration
// from the package inverse so the table always matches the field polynomial.
module RsDecodeInv
    import rs_pkg::*;
(
    input  logic [SYM_W-1:0] i_sym,
    output logic [SYM_W-1:0] o_inv
);

    logic [SYM_W-1:0] w_lut [1 << SYM_W];

    for (genvar gi = 0; gi < (1 << SYM_W); gi++) begin : g_lut
        assign w_lut[gi] = gf_inv(SYM_W'(gi));
    end

    assign o_inv = w_lut[i_sym];

endmodule

// File: rtl/rs_decode_mag.sv
// Forney error-magnitude and correction pipeline: three register stages that
// apply omega/lambda' corrections and report per-codeword error count and failure.
module rs_decode_mag #(
    parameter int SYM_W = 8,
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_sync,
    input  logic             i_in_valid,
    input  logic [SYM_W-1:0] i_data_in,
    input  logic             i_err_loc,
    input  logic [SYM_W-1:0] i_omega,
    input  logic [SYM_W-1:0] i_lambda_d,
    input  logic             i_last_in,
    input  logic [CNT_W-1:0] i_num_err,
    output logic             o_out_valid,
    output logic [SYM_W-1:0] o_data_out,
    output logic             o_last_out,
    output logic             o_done,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic             o_fail
);

    import rs_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Codeword tracking state
    cw_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_num_err;
    logic             r_fail_acc;

    // Stage 1
    logic             r_s1_valid;
    logic [SYM_W-1:0] r_s1_inv;
    logic [SYM_W-1:0] r_s1_omega;
    logic [SYM_W-1:0] r_s1_data;
    logic             r_s1_err;
    logic             r_s1_last;
    logic             r_s1_done;
    logic [CNT_W-1:0] r_s1_cnt;
    logic             r_s1_fail;

    // Stage 2
    logic             r_s2_valid;
    logic [SYM_W-1:0] r_s2_mag;
    logic [SYM_W-1:0] r_s2_data;
    logic             r_s2_err;
    logic             r_s2_last;
    logic             r_s2_done;
    logic [CNT_W-1:0] r_s2_cnt;
    logic             r_s2_fail;

    logic             w_accept;
    logic             w_active;
    logic [CNT_W-1:0] w_cnt_base;
    logic [CNT_W-1:0] w_num_base;
    logic             w_fail_base;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_fail_next;
    logic             w_final_fail;
    logic             w_cw_done;
    logic [SYM_W-1:0] w_inv;

    RsDecodeInv u_inv (
        .i_sym (i_lambda_d),
        .o_inv (w_inv)
    );

    assign w_accept = i_enable & i_in_valid;

    // A sync beat restarts bookkeeping in the same cycle it is counted, which also
    // covers aborting a codeword that is still open.
    assign w_active     = i_sync | (r_state == OPEN);
    assign w_cnt_base   = i_sync ? '0 : r_cnt;
    assign w_num_base   = i_sync ? i_num_err : r_num_err;
    assign w_fail_base  = i_sync ? 1'b0 : r_fail_acc;
    assign w_cnt_next   = (i_err_loc && (w_cnt_base != CNT_MAX)) ? (w_cnt_base + CNT_W'(1))
                                                                 : w_cnt_base;
    assign w_fail_next  = w_fail_base | (i_err_loc & (i_lambda_d == '0));
    assign w_final_fail = w_fail_next | (w_cnt_next != w_num_base);
    assign w_cw_done    = w_active & i_last_in;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_num_err  <= '0;
            r_fail_acc <= 1'b0;
        end else if (w_accept && w_active) begin
            r_state    <= i_last_in ? IDLE : OPEN;
            r_cnt      <= w_cnt_next;
            r_num_err  <= w_num_base;
            r_fail_acc <= w_fail_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_inv   <= '0;
            r_s1_omega <= '0;
            r_s1_data  <= '0;
            r_s1_err   <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_done  <= 1'b0;
            r_s1_cnt   <= '0;
            r_s1_fail  <= 1'b0;
        end else if (i_enable) begin
            r_s1_valid <= i_in_valid;
            r_s1_inv   <= w_inv;
            r_s1_omega <= i_omega;
            r_s1_data  <= i_data_in;
            r_s1_err   <= i_err_loc;
            r_s1_last  <= i_last_in;
            r_s1_done  <= i_in_valid & w_cw_done;
            r_s1_cnt   <= w_cnt_next;
            r_s1_fail  <= w_final_fail;
        end
    end

    // inv(0) is 0, so a root with lambda'==0 yields a zero magnitude and the
    // symbol passes through untouched.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_mag   <= '0;
            r_s2_data  <= '0;
            r_s2_err   <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_done  <= 1'b0;
            r_s2_cnt   <= '0;
            r_s2_fail  <= 1'b0;
        end else if (i_enable) begin
            r_s2_valid <= r_s1_valid;
            r_s2_mag   <= gf_mul(r_s1_omega, r_s1_inv);
            r_s2_data  <= r_s1_data;
            r_s2_err   <= r_s1_err;
            r_s2_last  <= r_s1_last;
            r_s2_done  <= r_s1_done;
            r_s2_cnt   <= r_s1_cnt;
            r_s2_fail  <= r_s1_fail;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_out_valid <= 1'b0;
            o_data_out  <= '0;
            o_last_out  <= 1'b0;
            o_done      <= 1'b0;
            o_err_cnt   <= '0;
            o_fail      <= 1'b0;
        end else if (i_enable) begin
            o_out_valid <= r_s2_valid;
            o_data_out  <= r_s2_err ? (r_s2_data ^ r_s2_mag) : r_s2_data;
            o_last_out  <= r_s2_valid & r_s2_last;
            o_done      <= r_s2_valid & r_s2_done;
            // Status is sticky until the next codeword completes.
            if (r_s2_valid && r_s2_done) begin
                o_err_cnt <= r_s2_cnt;
                o_fail    <= r_s2_fail;
            end
        end
    end

endmodule

// File: tb/tb_rs_decode_mag.sv
// Bench for rs_decode_mag: fixed vector table with exact latency, then directed
// and random sequences against a log/antilog field model and a codeword model.
module tb_rs_decode_mag;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       sync = 1'b0;
    logic       vin = 1'b0;
    logic       err_loc = 1'b0;
    logic       last_in = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] omega = '0;
    logic [7:0] lam = '0;
    logic [3:0] num_err = '0;

    logic       ov;
    logic [7:0] dout;
    logic       last_out;
    logic       done;
    logic [3:0] ecnt;
    logic       fail;

    always #5 clk = ~clk;

    rs_decode_mag #(.SYM_W(8), .CNT_W(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_enable    (en),
        .i_sync      (sync),
        .i_in_valid  (vin),
        .i_data_in   (data_in),
        .i_err_loc   (err_loc),
        .i_omega     (omega),
        .i_lambda_d  (lam),
        .i_last_in   (last_in),
        .i_num_err   (num_err),
        .o_out_valid (ov),
        .o_data_out  (dout),
        .o_last_out  (last_out),
        .o_done      (done),
        .o_err_cnt   (ecnt),
        .o_fail      (fail)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Field model via powers of the generator alpha = 2
    int gexp [512];
    int glog [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 0 || b == 0) return 8'h00;
        return 8'(gexp[glog[a] + glog[b]]);
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        if (a == 0) return 8'h00;
        return 8'(gexp[255 - glog[a]]);
    endfunction

    // Table vectors: inputs and the outputs expected exactly three cycles later
    typedef struct {
        logic       v, s, l, e;
        logic [7:0] om, ld, d;
        logic [3:0] ne;
        logic [7:0] xd;
        logic       xl, xdn;
        logic [3:0] xc;
        logic       xf;
    } vec_t;

    function automatic vec_t mk(input logic v, s, l, e, input logic [7:0] om, ld, d,
                                input logic [3:0] ne, input logic [7:0] xd,
                                input logic xl, xdn, input logic [3:0] xc, input logic xf);
        vec_t t;
        t.v = v; t.s = s; t.l = l; t.e = e; t.om = om; t.ld = ld; t.d = d; t.ne = ne;
        t.xd = xd; t.xl = xl; t.xdn = xdn; t.xc = xc; t.xf = xf;
        return t;
    endfunction

    // Scoreboard state
    typedef struct {
        int         due;
        logic [7:0] d;
        logic       l, dn;
        logic [3:0] c;
        logic       f;
    } exp_t;

    exp_t q[$];
    bit   sb_on = 0;
    bit   last_edge_en = 0;
    int   en_count = 0;
    bit   m_open = 0;
    int   m_cnt = 0;
    int   m_num = 0;
    bit   m_fail = 0;
    int   m_hold_cnt = 0;
    bit   m_hold_fail = 0;
    int   en_mode = 0;

    logic       s_ov = 0;
    logic [7:0] s_d = 0;
    logic       s_dn = 0;

    task automatic model_beat();
        exp_t r;
        r.d  = err_loc ? (data_in ^ gmul(omega, ginv(lam))) : data_in;
        r.l  = last_in;
        r.dn = 1'b0;
        if (sync) begin
            m_open = 1; m_cnt = 0; m_num = int'(num_err); m_fail = 0;
        end
        if (m_open) begin
            if (err_loc) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
            if (err_loc && lam == 0) m_fail = 1;
            if (last_in) begin
                r.dn = 1'b1;
                m_hold_cnt  = m_cnt;
                m_hold_fail = m_fail || (m_cnt != m_num);
                m_open = 0;
            end
        end
        r.c   = 4'(m_hold_cnt);
        r.f   = m_hold_fail;
        r.due = en_count + 2;
        q.push_back(r);
    endtask

    always @(posedge clk) begin
        last_edge_en = sb_on && rst_n && en;
        if (last_edge_en) begin
            en_count++;
            if (vin) model_beat();
        end
    end

    always @(negedge clk) begin
        exp_t r;
        bit   exp_v;
        if (sb_on && rst_n) begin
            if (last_edge_en) begin
                exp_v = (q.size() > 0) && (q[0].due == en_count);
                chk("sb_out_valid", 32'(ov), 32'(exp_v));
                if (exp_v) begin
                    r = q.pop_front();
                    chk("sb_data", 32'(dout), 32'(r.d));
                    chk("sb_last", 32'(last_out), 32'(r.l));
                    chk("sb_done", 32'(done), 32'(r.dn));
                    chk("sb_err_cnt", 32'(ecnt), 32'(r.c));
                    chk("sb_fail", 32'(fail), 32'(r.f));
                    if (r.dn) $display("[TB] codeword done err_cnt=%0d fail=%0d", ecnt, fail);
                end else begin
                    chk("sb_done_idle", 32'(done), 32'd0);
                end
            end else begin
                chk("hold_valid", 32'(ov), 32'(s_ov));
                chk("hold_data", 32'(dout), 32'(s_d));
                chk("hold_done", 32'(done), 32'(s_dn));
            end
        end
        s_ov = ov; s_d = dout; s_dn = done;
    end

    task automatic beat(input logic v, s, l, e, input logic [7:0] om, ld, d, input logic [3:0] ne);
        do begin
            @(negedge clk);
            case (en_mode)
                0:       en = 1'b1;
                1:       en = ~en;
                default: en = ($urandom_range(0, 3) != 0);
            endcase
            vin = v; sync = s; last_in = l; err_loc = e;
            omega = om; lam = ld; data_in = d; num_err = ne;
        end while (!en);
    endtask

    task automatic idle_beat();
        beat(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
             8'($urandom), 4'($urandom));
    endtask

    task automatic cw(input int len, input int ne, input int perr, input bit allow_zero);
        logic       e;
        logic [7:0] ld;
        for (int i = 0; i < len; i++) begin
            e  = ($urandom_range(0, 99) < perr);
            ld = (allow_zero && $urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            beat(1'b1, i == 0, i == len - 1, e, 8'($urandom), ld, 8'($urandom), 4'(ne));
            if (en_mode == 2 && $urandom_range(0, 5) == 0) idle_beat();
        end
    endtask

    task automatic drain();
        en_mode = 0;
        for (int i = 0; i < 12 && q.size() > 0; i++) idle_beat();
        repeat (2) idle_beat();
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset(input bit check_zero);
        @(negedge clk);
        vin = 0; sync = 0; last_in = 0; err_loc = 0; en = 1;
        #2 rst_n = 0;
        sb_on = 1;
        q.delete();
        m_open = 0; m_cnt = 0; m_num = 0; m_fail = 0; m_hold_cnt = 0; m_hold_fail = 0;
        #1;
        if (check_zero) begin
            chk("rst_out_valid", 32'(ov), 32'd0);
            chk("rst_data", 32'(dout), 32'd0);
            chk("rst_last", 32'(last_out), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_err_cnt", 32'(ecnt), 32'd0);
            chk("rst_fail", 32'(fail), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        vec_t tv [13];
        vec_t t;
        int   x;

        x = 1;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = x;
            glog[x] = i;
            x = x << 1;
            if ((x & 32'h100) != 0) x = x ^ 32'h187;
        end
        for (int i = 255; i < 512; i++) gexp[i] = gexp[i - 255];
        glog[0] = 0;

        //            v  s  l  e  om     ld     d      ne     xd     xl xdn xc     xf
        tv[0]  = mk(1, 0, 0, 1, 8'h01, 8'h02, 8'h10, 4'd0, 8'hD3, 0, 0, 4'd0, 0);
        tv[1]  = mk(1, 1, 0, 0, 8'h03, 8'h03, 8'h55, 4'd2, 8'h55, 0, 0, 4'd0, 0);
        tv[2]  = mk(1, 0, 0, 1, 8'h03, 8'h03, 8'h55, 4'd0, 8'h54, 0, 0, 4'd0, 0);
        tv[3]  = mk(1, 0, 0, 0, 8'h03, 8'h03, 8'h55, 4'd0, 8'h55, 0, 0, 4'd0, 0);
        tv[4]  = mk(1, 0, 1, 1, 8'h03, 8'h03, 8'h55, 4'd0, 8'h54, 1, 1, 4'd2, 0);
        tv[5]  = mk(1, 1, 0, 0, 8'h03, 8'h03, 8'h55, 4'd1, 8'h55, 0, 0, 4'd2, 0);
        tv[6]  = mk(1, 0, 0, 1, 8'h03, 8'h03, 8'h55, 4'd0, 8'h54, 0, 0, 4'd2, 0);
        tv[7]  = mk(1, 0, 0, 0, 8'h03, 8'h03, 8'h55, 4'd0, 8'h55, 0, 0, 4'd2, 0);
        tv[8]  = mk(1, 0, 1, 1, 8'h03, 8'h03, 8'h55, 4'd0, 8'h54, 1, 1, 4'd2, 1);
        tv[9]  = mk(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 4'd0, 8'h00, 0, 0, 4'd2, 1);
        tv[10] = mk(1, 1, 1, 1, 8'h05, 8'h00, 8'hAA, 4'd1, 8'hAA, 1, 1, 4'd1, 1);
        tv[11] = mk(1, 1, 1, 0, 8'h00, 8'h00, 8'h33, 4'd0, 8'h33, 1, 1, 4'd0, 0);
        tv[12] = mk(1, 0, 0, 1, 8'h07, 8'h01, 8'h00, 4'd0, 8'h07, 0, 0, 4'd0, 0);

        repeat (3) @(negedge clk);
        chk("reset_out_valid", 32'(ov), 32'd0);
        chk("reset_data", 32'(dout), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err_cnt", 32'(ecnt), 32'd0);
        chk("reset_fail", 32'(fail), 32'd0);
        rst_n = 1;
        en = 1;

        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            if (j >= 3) begin
                t = tv[j - 3];
                chk("tv_out_valid", 32'(ov), 32'(t.v));
                if (t.v) begin
                    chk("tv_data", 32'(dout), 32'(t.xd));
                    chk("tv_last", 32'(last_out), 32'(t.xl));
                    chk("tv_done", 32'(done), 32'(t.xdn));
                    chk("tv_err_cnt", 32'(ecnt), 32'(t.xc));
                    chk("tv_fail", 32'(fail), 32'(t.xf));
                end
                $display("[TB] vec %0d: valid=%0b data=%02h last=%0b done=%0b cnt=%0d fail=%0b",
                         j - 3, ov, dout, last_out, done, ecnt, fail);
            end
            if (j < 13) begin
                t = tv[j];
                vin = t.v; sync = t.s; last_in = t.l; err_loc = t.e;
                omega = t.om; lam = t.ld; data_in = t.d; num_err = t.ne;
            end else begin
                vin = 0; sync = 0; last_in = 0; err_loc = 0;
            end
        end

        // Scoreboard phase
        do_reset(1'b0);

        // Enable toggling every cycle over a 6-symbol codeword
        en_mode = 1;
        cw(6, 3, 50, 1'b0);
        drain();

        // Saturating counter: 18 roots against num_err = 15
        en_mode = 0;
        cw(18, 15, 100, 1'b0);
        drain();

        // Aborted codeword followed by a complete one
        en_mode = 0;
        beat(1, 1, 0, 0, 8'h11, 8'h22, 8'h01, 4'd1);
        beat(1, 0, 0, 1, 8'h13, 8'h05, 8'h02, 4'd0);
        beat(1, 0, 0, 0, 8'h00, 8'h01, 8'h03, 4'd0);
        cw(3, 1, 60, 1'b0);
        drain();

        // Reset while a codeword is in flight, then its stray tail, then a fresh one
        beat(1, 1, 0, 0, 8'h21, 8'h09, 8'h44, 4'd2);
        beat(1, 0, 0, 1, 8'h21, 8'h09, 8'h45, 4'd0);
        do_reset(1'b1);
        beat(1, 0, 1, 1, 8'h31, 8'h0A, 8'h46, 4'd0);
        cw(4, 2, 50, 1'b0);
        drain();

        // Random traffic with random enable, bubbles and stray idle beats
        en_mode = 2;
        for (int k = 0; k < 40; k++) begin
            cw($urandom_range(1, 8), $urandom_range(0, 4), 40, 1'b1);
            if ($urandom_range(0, 2) == 0)
                beat(1, 0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                     8'($urandom), 4'($urandom));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rs_decode_mag.md
RS_DECODE_MAG -- requirements
Module: rs_decode_mag

Interface
REQ-001 Parameter SYM_W, default 8: GF(2^8) symbol width; fixed at 8.
REQ-002 Parameter CNT_W, default 4: width of error-count ports.
REQ-003 CLK  in  1  single clock; all state on rising edge.
REQ-004 RESET  in  1  asynchronous, active-low reset.
REQ-005 enable  in  1  global advance; 0 freezes every register.
REQ-006 sync  in  1  first symbol of codeword; qualified by in_valid.
REQ-007 in_valid  in  1  input beat valid.
REQ-008 data_in  in  8  received codeword symbol.
REQ-009 err_loc  in  1  Chien root found at this symbol position.
REQ-010 omega  in  8  Omega(x) evaluated at this position.
REQ-011 lambda_d  in  8  Lambda'(x) evaluated at this position.
REQ-012 last_in  in  1  final symbol of codeword.
REQ-013 num_err  in  CNT_W  degree of Lambda; sampled on sync beat.
REQ-014 out_valid  out  1  output beat valid.
REQ-015 data_out  out  8  corrected symbol.
REQ-016 last_out  out  1  final corrected symbol.
REQ-017 done  out  1  one-cycle pulse coincident with last_out.
REQ-018 err_cnt  out  CNT_W  corrections in codeword; valid with done.
REQ-019 fail  out  1  codeword uncorrectable; valid with done.

Function
REQ-020 Field: GF(2^8), primitive polynomial x^8+x^7+x^2+x+1 (0x187).
REQ-021 Magnitude = omega * inv(lambda_d); data_out = data_in XOR magnitude if err_loc, else data_in unchanged.
REQ-022 Pipeline: S1 registers inv(lambda_d) and the side-band signals; S2 registers the GF product; S3 registers the XOR result and outputs.
REQ-023 Latency: exactly 3 enabled cycles from accepted in_valid to out_valid.
REQ-024 enable=0: all stages hold; outputs stay stable; no beat is lost or duplicated.
REQ-025 Stage valid bits propagate in_valid; a bubble (in_valid=0) yields out_valid=0 three enabled cycles later.
REQ-026 Codeword state machine: IDLE -> OPEN on sync beat. OPEN -> IDLE on last_in beat. sync+last_in on the same beat means a 1-symbol codeword; it returns straight to IDLE.
REQ-027 On a sync beat, num_err is latched and the correction counter is cleared. The counter then counts err_loc beats, including the sync beat.
REQ-028 Counter saturates at 2^CNT_W-1.
REQ-029 fail is set when any err_loc beat has lambda_d==0. That symbol passes uncorrected.
REQ-030 fail is also set when the final count != latched num_err.
REQ-031 err_cnt and fail are computed on the last_in beat. They are delayed to align with last_out/done.
REQ-032 A sync beat while OPEN aborts the open codeword: no done is issued for it, and counting restarts. Symbols already accepted still drain with their correction applied.
REQ-033 Beats in IDLE without sync pass through S1-S3 with correction applied. They never affect the counters or done.
REQ-034 err_cnt/fail hold their value between done pulses.

Reset
REQ-035 RESET low asynchronously clears: all stage valids, out_valid, last_out, done, fail, data_out=0, err_cnt=0, latched num_err=0, state=IDLE.
REQ-036 Reset mid-codeword discards in-flight beats. No done is issued afterwards until a new sync beat arrives.

Structure
REQ-037 A shared package rs_pkg holds: SYM_W, the field polynomial constant 8'h87 (low byte of 0x187), the state enum {IDLE, OPEN}, and a pure combinational GF-multiply function.
REQ-038 One sub-module: the existing RsDecodeInv LUT, instantiated once in S1. No other hierarchy.

Verification
REQ-039 sync=last_in=0, omega=1, lambda_d=2, err_loc=1, data_in=0x10 -> 3 cycles later data_out=0xD3 (inv(2)=0xC3).
REQ-040 Codeword of 4 symbols, num_err=2, err_loc on symbols 1 and 3 (omega=3, lambda_d=3, data_in=0x55) -> those outputs 0x54; done with err_cnt=2, fail=0.
REQ-041 Same codeword with num_err=1 -> done, err_cnt=2, fail=1.
REQ-042 err_loc with lambda_d=0, data_in=0xAA -> data_out=0xAA; fail=1 at done.
REQ-043 Toggle enable 1/0 every cycle over a 6-symbol codeword -> identical outputs and order; out_valid only changes on enabled cycles.
REQ-044 Second sync beat mid-codeword, then RESET pulsed during a later codeword -> no done for the aborted codeword; all outputs 0 immediately on reset; the next codeword decodes normally.
